// File: rtl/ram_init_loader.sv
// Boot-time loader for the SLC-3 program RAM.
// After every reset it copies a combinational image ROM into the RAM, then
// optionally reads every word back and compares it with the image. While
// busy is high this block owns the RAM port; when busy falls the CPU owns it.
// err is sticky and err_addr keeps the first address that read back wrong.
module ram_init_loader #(
    parameter int DEPTH  = 1024,
    parameter int AW     = 10,
    parameter bit VERIFY = 1'b1
) (
    input  logic          Clk,
    input  logic          Reset,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    input  logic [15:0]   ram_q,
    output logic [15:0]   ADDR,
    output logic [15:0]   data,
    output logic          wren,
    output logic          rden,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VREAD,
        S_VDRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_cnt;
    logic          w_last;

    logic          r_cmp_valid;
    logic [15:0]   r_cmp_exp;
    logic [AW-1:0] r_cmp_addr;
    logic          w_mismatch;

    logic          r_err;
    logic [AW-1:0] r_err_addr;

    assign w_last = (r_cnt == LAST_ADDR);

    // State register: any reset abandons the sequence and restarts from IDLE.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: each pass ends when the counter reaches the last word.
    always_comb begin
        // NOTE: default first, so no path through the case leaves the
        // variable unassigned and infers a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = S_WRITE;
            S_WRITE:  if (w_last) w_next_state = VERIFY ? S_VREAD : S_DONE;
            S_VREAD:  if (w_last) w_next_state = S_VDRAIN;
            S_VDRAIN: w_next_state = S_DONE;
            S_DONE:   w_next_state = S_DONE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Word counter: steps through 0..DEPTH-1 in each pass, then wraps to 0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (r_state == S_WRITE || r_state == S_VREAD) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Compare pipeline: hold the expected word and its address for one cycle
    // until the registered RAM read data arrives.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: the data/address payload is reset too; it is tiny, and a
        // clean value keeps err_addr well defined in simulation.
        if (Reset) begin
            r_cmp_valid <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_addr  <= '0;
        end else begin
            r_cmp_valid <= (r_state == S_VREAD);
            r_cmp_exp   <= rom_data;
            r_cmp_addr  <= r_cnt;
        end
    end

    assign w_mismatch = r_cmp_valid && (ram_q != r_cmp_exp);

    // Sticky error flag; the address is captured only on the first mismatch.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
            if (!r_err) begin
                r_err_addr <= r_cmp_addr;
            end
        end
    end

    // Output decode: strobes and write data follow the state and counter.
    always_comb begin
        wren = 1'b0;
        rden = 1'b0;
        data = '0;
        busy = 1'b1;
        done = 1'b0;
        case (r_state)
            S_WRITE: begin
                wren = 1'b1;
                data = rom_data;
            end
            S_VREAD: rden = 1'b1;
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign rom_addr = r_cnt;
    assign ADDR     = 16'(r_cnt);
    assign err      = r_err;
    assign err_addr = r_err_addr;

endmodule

// File: tb/tb_ram_init_loader.sv
// Self-checking bench for ram_init_loader: one instance with the read-back
// pass disabled, one with it enabled, each with its own image ROM and a RAM
// model that can flip bit 0 on read-back of chosen addresses.
module tb_ram_init_loader;

    localparam int DEPTH = 8;
    localparam int AW    = 4;
    localparam int WORDS = 1 << AW;

    logic          Clk;
    logic          Reset    [2];
    logic [AW-1:0] rom_addr [2];
    logic [15:0]   rom_data [2];
    logic [15:0]   ram_q    [2];
    logic [15:0]   ADDR     [2];
    logic [15:0]   data     [2];
    logic          wren     [2];
    logic          rden     [2];
    logic          busy     [2];
    logic          done     [2];
    logic          err      [2];
    logic [AW-1:0] err_addr [2];

    logic [15:0] rom_mem [2][WORDS];
    logic [15:0] ram_mem [2][WORDS];
    logic        corrupt [2][WORDS];

    int n_checks = 0;
    int n_pass   = 0;

    // Instance 0 has VERIFY=0, instance 1 has VERIFY=1.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign rom_data[g] = rom_mem[g][rom_addr[g]];

        ram_init_loader #(
            .DEPTH (DEPTH),
            .AW    (AW),
            .VERIFY(g == 1)
        ) u_dut (
            .Clk     (Clk),
            .Reset   (Reset[g]),
            .rom_addr(rom_addr[g]),
            .rom_data(rom_data[g]),
            .ram_q   (ram_q[g]),
            .ADDR    (ADDR[g]),
            .data    (data[g]),
            .wren    (wren[g]),
            .rden    (rden[g]),
            .busy    (busy[g]),
            .done    (done[g]),
            .err     (err[g]),
            .err_addr(err_addr[g])
        );
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // RAM model: synchronous write, registered read, optional bit-0 corruption.
    always @(posedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wren[k]) ram_mem[k][ADDR[k][AW-1:0]] <= data[k];
            if (rden[k]) ram_q[k] <= ram_mem[k][ADDR[k][AW-1:0]]
                                     ^ {15'd0, corrupt[k][ADDR[k][AW-1:0]]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One full load of instance k. bad marks addresses whose read-back is
    // corrupted; abort_at >= 0 asserts Reset during the write of that address.
    task automatic run_load(input int k, input logic [DEPTH-1:0] bad,
                            input bit fixed_rom, input int abort_at);
        int          w_a[$];
        int          w_e[$];
        logic [15:0] w_d[$];
        int          r_a[$];
        int          r_e[$];
        int          done_edge = -1;
        int          err_edge  = -1;
        int          both      = 0;
        int          oob       = 0;
        int          first_bad = DEPTH;
        bit          exp_err   = 1'b0;
        int          exp_done;

        for (int a = 0; a < WORDS; a++) begin
            rom_mem[k][a] = fixed_rom ? 16'(16'h3000 + a) : 16'($urandom);
            corrupt[k][a] = (a < DEPTH) ? bad[a] : 1'b0;
        end
        // Reference: verify finds the lowest corrupted address first.
        if (k == 1) begin
            for (int a = DEPTH - 1; a >= 0; a--) begin
                if (bad[a]) begin
                    exp_err   = 1'b1;
                    first_bad = a;
                end
            end
        end
        exp_done = (k == 1) ? 2 * DEPTH + 2 : DEPTH + 1;

        Reset[k] = 1'b1;
        #1;
        check($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd1);
        check($sformatf("rst_done%0d", k), 32'(done[k]), 32'd0);
        check($sformatf("rst_en%0d", k), {30'd0, wren[k], rden[k]}, 32'd0);
        check($sformatf("rst_err%0d", k), {27'd0, err[k], err_addr[k]}, 32'd0);
        check($sformatf("rst_addr%0d", k), 32'(ADDR[k]), 32'd0);
        @(negedge Clk);
        Reset[k] = 1'b0;

        for (int e = 1; e <= 2 * DEPTH + 10; e++) begin
            @(negedge Clk);
            if (wren[k] && rden[k]) both++;
            if (ADDR[k] >= 16'(DEPTH)) oob++;
            if (wren[k]) begin
                w_a.push_back(int'(ADDR[k]));
                w_d.push_back(data[k]);
                w_e.push_back(e);
            end
            if (rden[k]) begin
                r_a.push_back(int'(ADDR[k]));
                r_e.push_back(e);
            end
            if (abort_at >= 0 && wren[k] && int'(ADDR[k]) == abort_at) begin
                #2;
                Reset[k] = 1'b1;
                #1;
                check("abort_en", {30'd0, wren[k], rden[k]}, 32'd0);
                check("abort_busy_done", {30'd0, busy[k], done[k]}, 32'd2);
                check("abort_err", {27'd0, err[k], err_addr[k]}, 32'd0);
                check("abort_proto", 32'(both + oob), 32'd0);
                return;
            end
            if (err[k] && err_edge < 0) err_edge = e;
            if (done[k]) begin
                done_edge = e;
                check("busy_at_done", 32'(busy[k]), 32'd0);
                break;
            end
        end

        check($sformatf("done_edge%0d", k), 32'(done_edge), 32'(exp_done));
        check("wr_count", 32'(w_a.size()), 32'(DEPTH));
        for (int i = 0; i < w_a.size() && i < DEPTH; i++) begin
            check($sformatf("wr%0d_addr", i), 32'(w_a[i]), 32'(i));
            check($sformatf("wr%0d_data", i), 32'(w_d[i]), 32'(rom_mem[k][i]));
            check($sformatf("wr%0d_edge", i), 32'(w_e[i]), 32'(1 + i));
            check($sformatf("ram%0d", i), 32'(ram_mem[k][i]), 32'(rom_mem[k][i]));
        end
        check("rd_count", 32'(r_a.size()), (k == 1) ? 32'(DEPTH) : 32'd0);
        for (int i = 0; i < r_a.size() && i < DEPTH; i++) begin
            check($sformatf("rd%0d_addr", i), 32'(r_a[i]), 32'(i));
            check($sformatf("rd%0d_edge", i), 32'(r_e[i]), 32'(1 + DEPTH + 1 + i - 1));
        end
        check("err_final", 32'(err[k]), 32'(exp_err));
        check("err_addr_final", 32'(err_addr[k]), exp_err ? 32'(first_bad) : 32'd0);
        check("err_edge", 32'(err_edge), exp_err ? 32'(3 + DEPTH + first_bad) : 32'hFFFF_FFFF);
        check("wren_and_rden", 32'(both), 32'd0);
        check("addr_range", 32'(oob), 32'd0);
    endtask

    // DONE must be stable for 50 cycles; a reset pulse takes the port back at once.
    task automatic hold_done(input int k);
        int viol = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge Clk);
            if (wren[k] || rden[k] || busy[k] || !done[k]) viol++;
        end
        check($sformatf("hold_done%0d", k), 32'(viol), 32'd0);
        #2;
        Reset[k] = 1'b1;
        #1;
        check($sformatf("hold_rst%0d", k), {30'd0, busy[k], done[k]}, 32'd2);
    endtask

    initial begin
        Reset[0] = 1'b1;
        Reset[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < WORDS; a++) begin
                rom_mem[k][a] = '0;
                corrupt[k][a] = 1'b0;
            end
        end
        #12;

        run_load(0, '0, 1'b1, -1);
        hold_done(0);
        run_load(0, '0, 1'b0, -1);
        run_load(1, '0, 1'b1, -1);
        run_load(1, 8'h60, 1'b0, -1);
        hold_done(1);
        run_load(1, '0, 1'b0, 4);
        run_load(1, DEPTH'($urandom) & DEPTH'($urandom), 1'b0, -1);
        run_load(0, '0, 1'b0, 4);
        run_load(0, '0, 1'b0, -1);
        for (int r = 0; r < 4; r++) begin
            run_load(1, DEPTH'($urandom) & DEPTH'($urandom), 1'b0, -1);
        end
        run_load(1, 8'h80, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
